// File: rtl/main.sv
// Single-cycle RV32I-subset core whose only store target is a 32-bit
// display register, scanned out onto an 8-digit active-low 7-segment display.
module main #(
  parameter int          REFRESH_DIV = 16,
  parameter logic [31:0] ROM0        = 32'h00000093  // ROM word 0, overridable for test variants
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] AN,
  output logic [7:0] CT
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_BR  = 7'b1100011;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_ST  = 7'b0100011;

  logic [31:0]   pc, pc_next, instr;
  logic [31:0]   rf [32];
  logic [31:0]   disp;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;

  logic [6:0]  opc, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] a, b, imm_i, imm_b, imm_j, imm_u, wb_val;
  logic        wb_en, disp_we;

  // Instruction ROM: fixed counting loop, remainder filled with NOPs.
  always_comb begin
    case (pc[7:2])
      6'd0:    instr = ROM0;
      6'd1:    instr = 32'h00108093;
      6'd2:    instr = 32'h00102023;
      6'd3:    instr = 32'hFF9FF06F;
      default: instr = 32'h00000013;
    endcase
  end

  assign opc   = instr[6:0];
  assign rd    = instr[11:7];
  assign f3    = instr[14:12];
  assign rs1   = instr[19:15];
  assign rs2   = instr[24:20];
  assign f7    = instr[31:25];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};

  // x0 reads as zero regardless of what the array holds
  assign a = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign b = (rs2 == 5'd0) ? 32'd0 : rf[rs2];

  // Decode/execute: unrecognised encodings fall through as NOPs.
  always_comb begin
    wb_en   = 1'b0;
    wb_val  = '0;
    disp_we = 1'b0;
    pc_next = pc + 32'd4;
    case (opc)
      OPC_IMM: if (f3 == 3'b000) begin
        wb_en  = 1'b1;
        wb_val = a + imm_i;
      end
      OPC_OP: begin
        wb_en = 1'b1;
        case ({f7, f3})
          {7'h00, 3'b000}: wb_val = a + b;
          {7'h20, 3'b000}: wb_val = a - b;
          {7'h00, 3'b111}: wb_val = a & b;
          {7'h00, 3'b110}: wb_val = a | b;
          {7'h00, 3'b100}: wb_val = a ^ b;
          {7'h00, 3'b010}: wb_val = {31'd0, $signed(a) < $signed(b)};
          {7'h00, 3'b011}: wb_val = {31'd0, a < b};
          default:         wb_en  = 1'b0;
        endcase
      end
      OPC_LUI: begin
        wb_en  = 1'b1;
        wb_val = imm_u;
      end
      OPC_BR:
        if ((f3 == 3'b000 && a == b) || (f3 == 3'b001 && a != b))
          pc_next = pc + imm_b;
      OPC_JAL: begin
        wb_en   = 1'b1;
        wb_val  = pc + 32'd4;
        pc_next = pc + imm_j;
      end
      OPC_ST: if (f3 == 3'b010) disp_we = 1'b1;
      default: ;
    endcase
  end

  // Retire one instruction per edge: PC, register write-back, display store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc   <= '0;
      disp <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      pc <= pc_next;
      if (wb_en && rd != 5'd0) rf[rd] <= wb_val;
      if (disp_we) disp <= b;
    end
  end

  // Refresh divider and digit index; idx advances when the divider wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CW'(REFRESH_DIV - 1)) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_an
    assign AN[g] = (idx != 3'(g));
  end

  // Hex-to-segment decode of the selected nibble; DP held off.
  always_comb begin
    case (disp[{idx, 2'b00} +: 4])
      4'h0: CT = 8'hC0;
      4'h1: CT = 8'hF9;
      4'h2: CT = 8'hA4;
      4'h3: CT = 8'hB0;
      4'h4: CT = 8'h99;
      4'h5: CT = 8'h92;
      4'h6: CT = 8'h82;
      4'h7: CT = 8'hF8;
      4'h8: CT = 8'h80;
      4'h9: CT = 8'h90;
      4'hA: CT = 8'h88;
      4'hB: CT = 8'h83;
      4'hC: CT = 8'hC6;
      4'hD: CT = 8'hA1;
      4'hE: CT = 8'h86;
      default: CT = 8'h8E;
    endcase
  end

endmodule

// File: tb/tb_main.sv
// Directed bench: four builds of main (stock program, LUI-seeded scan,
// near-wrap counter, x0 write attempt) stepped together and checked per edge.
module tb_main;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] an_c, ct_c, an_s, ct_s, an_w, ct_w, an_z, ct_z;
  int         ntot = 0;
  int         nbad = 0;

  logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  always #5 clk = ~clk;

  main #(.REFRESH_DIV(16))                             u_cnt  (.clk(clk), .rst_n(rst_n), .AN(an_c), .CT(ct_c));
  main #(.REFRESH_DIV(16), .ROM0(32'h89ABD0B7))        u_scan (.clk(clk), .rst_n(rst_n), .AN(an_s), .CT(ct_s));
  main #(.REFRESH_DIV(2),  .ROM0(32'hFFE00093))        u_wrap (.clk(clk), .rst_n(rst_n), .AN(an_w), .CT(ct_w));
  main #(.REFRESH_DIV(1),  .ROM0(32'h00500013))        u_x0   (.clk(clk), .rst_n(rst_n), .AN(an_z), .CT(ct_z));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] an_exp(input int i);
    logic [7:0] one;
    one = 8'h01;
    return ~(one << i);
  endfunction

  function automatic logic [7:0] ct_exp(input logic [31:0] d, input int i);
    logic [3:0] nb;
    nb = d[4*i +: 4];
    return seg_tbl[nb];
  endfunction

  // Step n edges after reset release, checking every build after each edge.
  task automatic run(input int nedge);
    logic [31:0] dc, ds, dw;
    int i16, i2, i1;
    for (int k = 1; k <= nedge; k++) begin
      @(posedge clk);
      #1;
      dc  = 32'(k / 3);
      ds  = (k < 3) ? 32'd0 : 32'h89ABD000 + 32'(k / 3);
      dw  = (k < 3) ? 32'd0 : 32'hFFFFFFFE + 32'(k / 3);
      i16 = (k / 16) % 8;
      i2  = (k / 2) % 8;
      i1  = k % 8;
      chk("cnt_disp",  u_cnt.disp,  dc);
      chk("cnt_an",    32'(an_c),   32'(an_exp(i16)));
      chk("cnt_ct",    32'(ct_c),   32'(ct_exp(dc, i16)));
      chk("scan_disp", u_scan.disp, ds);
      chk("scan_an",   32'(an_s),   32'(an_exp(i16)));
      chk("scan_ct",   32'(ct_s),   32'(ct_exp(ds, i16)));
      chk("wrap_disp", u_wrap.disp, dw);
      chk("wrap_an",   32'(an_w),   32'(an_exp(i2)));
      chk("wrap_ct",   32'(ct_w),   32'(ct_exp(dw, i2)));
      chk("x0_reg",    u_x0.rf[0],  32'd0);
      chk("x0_disp",   u_x0.disp,   dc);
      chk("x0_an",     32'(an_z),   32'(an_exp(i1)));
      chk("x0_ct",     32'(ct_z),   32'(ct_exp(dc, i1)));
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_an_c"}, 32'(an_c), 32'hFE);
    chk({tag, "_ct_c"}, 32'(ct_c), 32'hC0);
    chk({tag, "_an_s"}, 32'(an_s), 32'hFE);
    chk({tag, "_ct_s"}, 32'(ct_s), 32'hC0);
    chk({tag, "_an_w"}, 32'(an_w), 32'hFE);
    chk({tag, "_an_z"}, 32'(an_z), 32'hFE);
    chk({tag, "_pc"},   u_cnt.pc,    32'd0);
    chk({tag, "_disp"}, u_scan.disp, 32'd0);
    chk({tag, "_x1"},   u_scan.rf[1], 32'd0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_rst("rst");
    @(negedge clk);
    rst_n = 1'b1;
    run(200);
    // drop reset between edges while idx and DISP are both non-trivial
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_rst("midrst");
    @(posedge clk);
    #1;
    chk_rst("midrst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    run(20);
    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

endmodule

// File: doc/main.md
MAIN -- requirements
Module: main

Interface
REQ-001 Parameter REFRESH_DIV, default 16, is the number of clk cycles each display digit stays selected; it must be at least 1.
REQ-002 clk  input  1  system clock; all state is updated on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 AN  output  8  digit anode enables, active-low; AN[i] selects digit i.
REQ-005 CT  output  8  segment cathodes, active-low; CT[0..6]=segments a..g, CT[7]=decimal point.

Function
REQ-006 The block SHALL contain a single-cycle RV32I-subset core: 32-bit PC, a 32x32 register file, an ALU and a 64-word instruction ROM indexed by PC[7:2].
REQ-007 Each rising clk edge SHALL fetch, execute and retire exactly one instruction.
REQ-008 Register x0 SHALL always read 0, and writes to x0 SHALL be discarded.
REQ-009 Supported instructions: ADDI, ADD, SUB, AND, OR, XOR, SLT, SLTU, LUI, BEQ, BNE, JAL and SW.
REQ-010 Any other encoding SHALL execute as a NOP: PC advances by 4 and no state changes.
REQ-011 Arithmetic SHALL be 32-bit wrap-around with no overflow trap.
REQ-012 SLT SHALL compare as signed and SLTU as unsigned; the result is 1 or 0.
REQ-013 Immediates SHALL be sign-extended per the RV32I I/S/B/J formats; LUI SHALL load imm<<12.
REQ-014 A taken branch or JAL SHALL set PC = PC + imm; otherwise PC = PC + 4.
REQ-015 JAL SHALL write PC+4 to rd.
REQ-016 A branch or JAL target SHALL be used as computed; PC[1:0] of the target is ignored for fetch.
REQ-017 SW SHALL write rs2 into a 32-bit display register DISP, regardless of the address.
REQ-018 There is no data memory; SW has no other effect.
REQ-019 ROM words 0..3 SHALL hold, in order: addi x1,x0,0 (0x00000093); addi x1,x1,1 (0x00108093); sw x1,0(x0) (0x00102023); jal x0,-8 (0xFF9FF06F).
REQ-020 ROM words 4..63 SHALL hold 0x00000013 (NOP).
REQ-021 Display scan: a refresh counter counts 0..REFRESH_DIV-1, then wraps to 0.
REQ-022 On each refresh-counter wrap, a 3-bit digit index SHALL increment modulo 8.
REQ-023 AN SHALL drive exactly one bit low: AN[idx]=0 and all other bits 1.
REQ-024 Digit idx SHALL display the hex nibble DISP[4*idx+3:4*idx].
REQ-025 CT SHALL be a combinational function of idx and DISP. CT[7] is always 1 (DP off).
REQ-026 CT values per hex digit 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
REQ-027 If SW and a digit change occur in the same cycle, the new digit SHALL show the updated DISP from the next cycle onward.

Reset
REQ-028 While rst_n=0, the block SHALL immediately and asynchronously set: PC=0; all registers=0; DISP=0; refresh counter=0; idx=0.
REQ-029 Consequently, during reset AN=0xFE and CT=0xC0.
REQ-030 Reset SHALL be honoured mid-program and mid-scan; execution restarts at PC=0 on the first rising edge after rst_n rises.
REQ-031 No output SHALL be X or Z after reset is asserted.

Verification
REQ-032 Hold rst_n=0 -> AN=0xFE, CT=0xC0, PC=0, DISP=0.
REQ-033 Release reset, count rising edges -> DISP=1 after edge 3, DISP=2 after edge 6, DISP=n after edge 3n.
REQ-034 REFRESH_DIV=16, DISP=0x89ABCDEF -> AN walks FE,FD,FB,F7,EF,DF,BF,7F every 16 cycles; CT = 8E,86,A1,C6,83,88,90,80.
REQ-035 Assert rst_n=0 between clock edges mid-run -> outputs return to AN=0xFE, CT=0xC0 at once; after release, the counting sequence restarts from 1.
REQ-036 After 3*0xFFFFFFFF+3 edges -> DISP wraps to 0; no other state is corrupted.
REQ-037 Directly check register x0 after a write attempt (forced ROM variant "addi x0,x0,5") -> x0 reads 0.
